instr_fetch: RTL and testbench

Instruction fetch datapath driven by the control state machine's one-hot strobes (FETCH, EXEC1, EXEC2). It holds the program counter (PC) and the instruction register (IR), and issues instruction-memory requests. It returns the EXTRA and P status inputs to the control state machine, so it sits directly beside that block in the control loop. It absorbs variable memory latency by stalling EXEC1 through P.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/instr_fetch.sv | 75 +++++++
 tb/tb_instr_fetch.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch datapath:
// opcode field placement, two-cycle class test and strobe legality.
package fetch_pkg;

    localparam int OPCODE_W = 4;

    function automatic int opcode_lsb(int data_w);
        return data_w - OPCODE_W;
    endfunction

    function automatic logic needs_extra(logic [OPCODE_W-1:0] opcode);
        return opcode[3];
    endfunction

    function automatic logic strobe_legal(logic [2:0] strobes);
        return (strobes == 3'b001) || (strobes == 3'b010) ||
               (strobes == 3'b100);
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch datapath: PC, IR and memory request issue,
// stalling EXEC1 via P until the instruction word has been captured.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 8,
    parameter int              DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FETCH,
    input  logic              EXEC1,
    input  logic              EXEC2,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_VALID,
    input  logic              JUMP,
    input  logic [ADDR_W-1:0] JUMP_ADDR,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] IR,
    output logic              EXTRA,
    output logic              P
);

    localparam int OPC_LSB = opcode_lsb(DATA_W);

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic              pending;
    logic              ir_valid;
    logic              legal;
    logic              active;
    logic              ready;
    logic              two_cycle;

    assign legal  = strobe_legal({FETCH, EXEC1, EXEC2});
    assign active = legal && !RESET;
    // JUMP only takes effect once the current word is in IR
    assign ready  = (EXEC1 && ir_valid) || EXEC2;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc       <= RESET_PC;
            ir       <= '0;
            pending  <= 1'b0;
            ir_valid <= 1'b0;
        end else if (legal) begin
            if (FETCH) begin
                pc       <= pc + ADDR_W'(1);
                pending  <= 1'b1;
                ir_valid <= 1'b0;
            end else if (EXEC1 && !ir_valid) begin
                if (pending && MEM_VALID) begin
                    ir       <= MEM_RDATA;
                    ir_valid <= 1'b1;
                    pending  <= 1'b0;
                end
            end else if (ready && JUMP) begin
                pc <= JUMP_ADDR;
            end
        end
    end

    assign two_cycle = needs_extra(ir[OPC_LSB +: OPCODE_W]);

    assign MEM_REQ  = active && FETCH;
    assign MEM_ADDR = pc;
    assign PC       = pc;
    assign IR       = ir;
    assign P        = active && EXEC1 && !ir_valid;
    assign EXTRA    = active && ready && two_cycle;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus
// randomized instruction flow checked against a cycle-level model.
module tb_instr_fetch;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          FETCH;
    logic          EXEC1;
    logic          EXEC2;
    logic [DW-1:0] MEM_RDATA;
    logic          MEM_VALID;
    logic          JUMP;
    logic [AW-1:0] JUMP_ADDR;
    logic          MEM_REQ;
    logic [AW-1:0] MEM_ADDR;
    logic [AW-1:0] PC;
    logic [DW-1:0] IR;
    logic          EXTRA;
    logic          P;

    int n_assert = 0;
    int n_fail   = 0;

    logic [AW-1:0] pc_m;
    logic [DW-1:0] ir_m;

    instr_fetch #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .RESET_PC('0)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .FETCH    (FETCH),
        .EXEC1    (EXEC1),
        .EXEC2    (EXEC2),
        .MEM_RDATA(MEM_RDATA),
        .MEM_VALID(MEM_VALID),
        .JUMP     (JUMP),
        .JUMP_ADDR(JUMP_ADDR),
        .MEM_REQ  (MEM_REQ),
        .MEM_ADDR (MEM_ADDR),
        .PC       (PC),
        .IR       (IR),
        .EXTRA    (EXTRA),
        .P        (P)
    );

    always #5 CLK = ~CLK;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic strobe(logic f, logic e1, logic e2);
        FETCH = f;
        EXEC1 = e1;
        EXEC2 = e2;
    endtask

    task automatic chk_outs(string tag, logic req, logic p, logic extra);
        chk({tag, "_req"}, 32'(MEM_REQ), 32'(req));
        chk({tag, "_p"}, 32'(P), 32'(p));
        chk({tag, "_extra"}, 32'(EXTRA), 32'(extra));
    endtask

    task automatic chk_regs(string tag);
        chk({tag, "_pc"}, 32'(PC), 32'(pc_m));
        chk({tag, "_addr"}, 32'(MEM_ADDR), 32'(pc_m));
        chk({tag, "_ir"}, 32'(IR), 32'(ir_m));
    endtask

    // FETCH cycle; stray JUMP and MEM_VALID must be ignored
    task automatic do_fetch(string tag);
        strobe(1'b1, 1'b0, 1'b0);
        JUMP      = 1'($urandom_range(0, 1));
        JUMP_ADDR = AW'($urandom);
        MEM_VALID = 1'($urandom_range(0, 1));
        MEM_RDATA = DW'($urandom);
        #3;
        chk_outs(tag, 1'b1, 1'b0, 1'b0);
        chk({tag, "_addr"}, 32'(MEM_ADDR), 32'(pc_m));
        tick();
        pc_m = pc_m + 1'b1;
        chk_regs({tag, "_post"});
    endtask

    // EXEC1 with latency lat, then EXEC2 when the opcode needs it
    task automatic do_exec(string tag, int lat, logic [DW-1:0] data,
                           logic jmp, logic [AW-1:0] jaddr);
        logic extra;
        strobe(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= lat; k++) begin
            MEM_VALID = (k == lat);
            MEM_RDATA = (k == lat) ? data : DW'($urandom);
            JUMP      = 1'($urandom_range(0, 1));
            JUMP_ADDR = AW'($urandom);
            #3;
            chk_outs({tag, "_wait"}, 1'b0, 1'b1, 1'b0);
            tick();
            chk({tag, "_wait_pc"}, 32'(PC), 32'(pc_m));
        end
        ir_m  = data;
        extra = data[DW-1];
        MEM_VALID = 1'($urandom_range(0, 1));
        MEM_RDATA = DW'($urandom);
        JUMP      = extra ? 1'b0 : jmp;
        JUMP_ADDR = jaddr;
        #3;
        chk_outs({tag, "_rdy"}, 1'b0, 1'b0, extra);
        chk({tag, "_rdy_ir"}, 32'(IR), 32'(ir_m));
        tick();
        if (!extra && jmp)
            pc_m = jaddr;
        chk_regs({tag, "_rdy_post"});
        if (extra) begin
            strobe(1'b0, 1'b0, 1'b1);
            JUMP      = jmp;
            JUMP_ADDR = jaddr;
            MEM_VALID = 1'($urandom_range(0, 1));
            MEM_RDATA = DW'($urandom);
            #3;
            chk_outs({tag, "_ex2"}, 1'b0, 1'b0, 1'b1);
            tick();
            if (jmp)
                pc_m = jaddr;
            chk_regs({tag, "_ex2_post"});
        end
    endtask

    initial begin
        RESET     = 1'b1;
        strobe(1'b1, 1'b0, 1'b0);
        MEM_VALID = 1'b1;
        MEM_RDATA = 16'hDEAD;
        JUMP      = 1'b1;
        JUMP_ADDR = 8'h55;
        pc_m      = '0;
        ir_m      = '0;
        tick();
        #3;
        chk_outs("reset", 1'b0, 1'b0, 1'b0);
        tick();
        chk_regs("reset");

        RESET = 1'b0;
        strobe(1'b0, 1'b0, 1'b0);
        MEM_VALID = 1'b0;
        JUMP      = 1'b0;
        #3;
        chk_outs("idle", 1'b0, 1'b0, 1'b0);
        tick();

        do_fetch("f0");
        do_exec("i1234", 3, 16'h1234, 1'b0, 8'h00);
        do_fetch("f1");
        do_exec("i8001", 3, 16'h8001, 1'b1, 8'h40);
        do_fetch("f40");
        do_exec("jff", 1, 16'h0002, 1'b1, 8'hFF);
        do_fetch("wrap");
        chk("wrap_pc0", 32'(PC), 32'h0);

        // illegal strobes with a request outstanding hold everything
        strobe(1'b1, 1'b1, 1'b0);
        MEM_VALID = 1'b1;
        MEM_RDATA = 16'hF00D;
        JUMP      = 1'b1;
        JUMP_ADDR = 8'h33;
        #3;
        chk_outs("ill_a", 1'b0, 1'b0, 1'b0);
        tick();
        chk_regs("ill_a");
        strobe(1'b0, 1'b1, 1'b1);
        #3;
        chk_outs("ill_b", 1'b0, 1'b0, 1'b0);
        tick();
        chk_regs("ill_b");
        do_exec("after_ill", 2, 16'h9ABC, 1'b0, 8'h00);

        // reset during the EXEC1 wait, stale return afterwards
        do_fetch("fr");
        strobe(1'b0, 1'b1, 1'b0);
        MEM_VALID = 1'b0;
        JUMP      = 1'b0;
        #3;
        chk_outs("rst_wait", 1'b0, 1'b1, 1'b0);
        tick();
        RESET = 1'b1;
        #3;
        chk_outs("rst_mid", 1'b0, 1'b0, 1'b0);
        tick();
        pc_m  = '0;
        ir_m  = '0;
        RESET = 1'b0;
        strobe(1'b0, 1'b0, 1'b0);
        MEM_VALID = 1'b1;
        MEM_RDATA = 16'hBEEF;
        #3;
        chk_outs("stale", 1'b0, 1'b0, 1'b0);
        tick();
        chk_regs("stale");
        strobe(1'b0, 1'b1, 1'b0);
        #3;
        chk_outs("stale_e1", 1'b0, 1'b1, 1'b0);
        tick();
        chk_regs("stale_e1");
        #3;
        chk_outs("stale_e1b", 1'b0, 1'b1, 1'b0);
        tick();

        for (int i = 0; i < 20; i++) begin
            do_fetch("rnd_f");
            do_exec("rnd_x", int'($urandom_range(1, 4)), DW'($urandom),
                    ($urandom_range(0, 9) < 3), AW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
